// File: rtl/uart_packet_pkg.sv
// Shared constants for the UART packet layer: message types, header length
// and the packet engine state encoding.
package uart_packet_pkg;

    localparam int HDR_LEN = 4;

    localparam logic [7:0] TYPE_INFO     = 8'd0;
    localparam logic [7:0] TYPE_INVALID  = 8'd1;
    localparam logic [7:0] TYPE_PUSH_JOB = 8'd2;
    localparam logic [7:0] TYPE_ACK      = 8'd3;
    localparam logic [7:0] TYPE_NONCE    = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DISCARD,
        ST_PARSE,
        ST_SEND
    } state_e;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Serialises one reply frame (length, two zero bytes, type, payload LSB first)
// or a single PING byte into uart transmit strobes, one byte per free slot.
module uart_tx_sequencer
    import uart_packet_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        ping_i,
    input  logic [7:0]  len_i,
    input  logic [7:0]  type_i,
    input  logic [63:0] payload_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_byte_o,
    output logic        active_o
);

    logic        active_q;
    logic        tx_start_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  idx_q;
    logic        ping_q;
    logic [7:0]  len_q;
    logic [7:0]  type_q;
    logic [63:0] payload_q;

    logic        cur_active;
    logic        cur_ping;
    logic [7:0]  cur_len;
    logic [7:0]  cur_type;
    logic [7:0]  cur_idx;
    logic [63:0] cur_payload;
    logic        fire;
    logic        last;
    logic [7:0]  cur_byte;

    function automatic logic [7:0] frame_byte(input logic ping, input logic [7:0] idx,
                                              input logic [7:0] len, input logic [7:0] typ,
                                              input logic [63:0] pl);
        logic [2:0] off;
        off = 3'(idx - 8'(HDR_LEN));
        if (ping || idx == 8'd1 || idx == 8'd2) return 8'h00;
        if (idx == 8'd0) return len;
        if (idx == 8'd3) return typ;
        return pl[{off, 3'b000} +: 8];
    endfunction

    // A load is usable on the same edge so the first byte leaves without a bubble.
    always_comb begin
        cur_active  = load_i | active_q;
        cur_ping    = load_i ? ping_i    : ping_q;
        cur_len     = load_i ? len_i     : len_q;
        cur_type    = load_i ? type_i    : type_q;
        cur_payload = load_i ? payload_i : payload_q;
        cur_idx     = load_i ? 8'd0      : idx_q;
        fire        = cur_active && !tx_busy_i && !tx_start_q;
        last        = cur_ping || (cur_idx == cur_len - 8'd1);
        cur_byte    = frame_byte(cur_ping, cur_idx, cur_len, cur_type, cur_payload);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            idx_q      <= 8'd0;
        end else begin
            tx_start_q <= fire;
            if (fire) begin
                tx_byte_q <= cur_byte;
                idx_q     <= cur_idx + 8'd1;
                active_q  <= !last;
            end else begin
                idx_q    <= cur_idx;
                active_q <= cur_active;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            ping_q    <= ping_i;
            len_q     <= len_i;
            type_q    <= type_i;
            payload_q <= payload_i;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_byte_o  = tx_byte_q;
    assign active_o   = active_q;

endmodule

// File: rtl/uart_packet_engine.sv
// Packet layer above the byte uart: frames length-prefixed requests, answers
// PING/GET_INFO, latches PUSH_JOB work and reports golden nonces.
module uart_packet_engine
    import uart_packet_pkg::*;
#(
    parameter int          MSG_BUF_LEN    = 60,
    parameter int          WORK_BYTES     = 12,
    parameter logic [63:0] INFO_WORD      = 64'hDEADBEEF13370D13,
    parameter int          TIMEOUT_CYCLES = 12000000
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_byte,
    input  logic                    nonce_valid,
    input  logic [31:0]             nonce,
    output logic [WORK_BYTES*8-1:0] work_data,
    output logic                    work_valid,
    output logic                    proto_error
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int              BUF_W   = MSG_BUF_LEN * 8;
    localparam int              WORK_W  = WORK_BYTES * 8;
    localparam logic [8:0]      MAX_LEN = 9'(MSG_BUF_LEN + HDR_LEN);
    localparam logic [7:0]      JOB_LEN = 8'(WORK_BYTES + HDR_LEN);
    localparam logic [7:0]      HDR_B   = 8'(HDR_LEN);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [7:0]        type_q;
    logic [TO_W-1:0]   to_q;
    logic [WORK_W-1:0] work_q;
    logic              work_valid_q;
    logic              perr_q;
    logic              npend_q;
    logic [31:0]       nonce_q;
    logic [BUF_W-1:0]  pbuf_q;

    logic        is_info;
    logic        is_job;
    logic        nonce_go;
    logic        seq_active;
    logic        ld;
    logic        ld_ping;
    logic [7:0]  ld_len;
    logic [7:0]  ld_type;
    logic [63:0] ld_payload;

    always_comb begin
        is_info    = (type_q == TYPE_INFO) && (len_q == HDR_B);
        is_job     = (type_q == TYPE_PUSH_JOB) && (len_q == JOB_LEN);
        nonce_go   = (state_q == ST_IDLE) && !rx_valid && npend_q && !seq_active;
        ld         = 1'b0;
        ld_ping    = 1'b0;
        ld_len     = HDR_B;
        ld_type    = TYPE_INVALID;
        ld_payload = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == 8'h00) begin
                        ld      = 1'b1;
                        ld_ping = 1'b1;
                    end else if (rx_byte < HDR_B) begin
                        ld = 1'b1;
                    end
                end else if (nonce_go) begin
                    ld         = 1'b1;
                    ld_len     = HDR_B + 8'd4;
                    ld_type    = TYPE_NONCE;
                    ld_payload = {32'h0, nonce_q};
                end
            end
            ST_DISCARD: ld = rx_valid && (cnt_q == len_q);
            ST_PARSE: begin
                ld = 1'b1;
                if (is_info) begin
                    ld_len     = HDR_B + 8'd8;
                    ld_type    = TYPE_INFO;
                    ld_payload = INFO_WORD;
                end else if (is_job) begin
                    ld_type = TYPE_ACK;
                end
            end
            default: ;
        endcase
    end

    // cnt_q holds the 1-based position of the byte about to arrive.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            type_q       <= 8'd0;
            to_q         <= '0;
            work_q       <= '0;
            work_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            npend_q      <= 1'b0;
            nonce_q      <= 32'h0;
        end else begin
            work_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            if (nonce_valid) begin
                npend_q <= 1'b1;
                nonce_q <= nonce;
            end else if (nonce_go) begin
                npend_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    to_q <= '0;
                    if (rx_valid) begin
                        if (rx_byte != 8'h00 && rx_byte < HDR_B) begin
                            perr_q  <= 1'b1;
                            state_q <= ST_SEND;
                        end else if (rx_byte != 8'h00) begin
                            len_q <= rx_byte;
                            cnt_q <= 8'd2;
                            if ({1'b0, rx_byte} > MAX_LEN) begin
                                perr_q  <= 1'b1;
                                state_q <= ST_DISCARD;
                            end else begin
                                state_q <= ST_READ;
                            end
                        end
                    end else if (nonce_go) begin
                        state_q <= ST_SEND;
                    end
                end
                ST_READ, ST_DISCARD: begin
                    if (rx_valid) begin
                        to_q  <= '0;
                        cnt_q <= cnt_q + 8'd1;
                        if (state_q == ST_READ && cnt_q == HDR_B) type_q <= rx_byte;
                        if (cnt_q == len_q) state_q <= (state_q == ST_READ) ? ST_PARSE : ST_SEND;
                    end else if (to_q >= TO_LAST) begin
                        perr_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                ST_PARSE: begin
                    state_q <= ST_SEND;
                    if (is_job) begin
                        work_q       <= pbuf_q[BUF_W-1 -: WORK_W];
                        work_valid_q <= 1'b1;
                    end else if (!is_info) begin
                        perr_q <= 1'b1;
                    end
                end
                ST_SEND: if (!seq_active) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Payload enters at the top, so the newest WORK_BYTES sit in the top slice.
    always_ff @(posedge sys_clk) begin
        if (state_q == ST_READ && rx_valid && cnt_q > HDR_B)
            pbuf_q <= {rx_byte, pbuf_q[BUF_W-1:8]};
    end

    generate
        if (WORK_BYTES < MSG_BUF_LEN) begin : g_spare
            logic buf_unused;
            assign buf_unused = ^pbuf_q[BUF_W-WORK_W-1:0];
        end
    endgenerate

    uart_tx_sequencer u_seq (
        .clk_i     (sys_clk),
        .rst_i     (rst),
        .load_i    (ld),
        .ping_i    (ld_ping),
        .len_i     (ld_len),
        .type_i    (ld_type),
        .payload_i (ld_payload),
        .tx_busy_i (tx_busy),
        .tx_start_o(tx_start),
        .tx_byte_o (tx_byte),
        .active_o  (seq_active)
    );

    assign work_data   = work_q;
    assign work_valid  = work_valid_q;
    assign proto_error = perr_q;

endmodule

// File: tb/tb_uart_packet_engine.sv
// Directed bench for uart_packet_engine with a small uart busy model and a
// byte collector on the transmit side.
module tb_uart_packet_engine;

    localparam int TIMEOUT = 200;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        nonce_valid = 1'b0;
    logic [31:0] nonce = 32'h0;
    logic [95:0] work_data;
    logic        work_valid;
    logic        proto_error;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    uart_packet_engine #(
        .MSG_BUF_LEN   (60),
        .WORK_BYTES    (12),
        .INFO_WORD     (64'hDEADBEEF13370D13),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .nonce_valid(nonce_valid),
        .nonce      (nonce),
        .work_data  (work_data),
        .work_valid (work_valid),
        .proto_error(proto_error)
    );

    // uart model: busy for 4 cycles after each transmit strobe
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge sys_clk) begin
        if (tx_start) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0]  txq[$];
    logic [7:0]  pkt[$];
    int          wv_cnt = 0;
    int          pe_cnt = 0;
    int          viol = 0;
    logic        prev_start = 1'b0;
    logic [95:0] work_cap = '0;

    always @(negedge sys_clk) begin
        if (tx_start) begin
            txq.push_back(tx_byte);
            if (prev_start || tx_busy) viol++;
        end
        prev_start = tx_start;
        if (work_valid) begin
            wv_cnt++;
            work_cap = work_data;
        end
        if (proto_error) pe_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input int gap);
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i]);
            if (i != pkt.size() - 1) repeat (gap) @(negedge sys_clk);
        end
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) @(negedge sys_clk);
        repeat (30) @(negedge sys_clk);
    endtask

    task automatic pulse_nonce(input logic [31:0] v);
        @(negedge sys_clk);
        nonce_valid = 1'b1;
        nonce       = v;
        @(negedge sys_clk);
        nonce_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        tests_run++;
        if (tx_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_byte got %02h want 00", tx_byte); end
        tests_run++;
        if (work_data !== 96'h0) begin tests_failed++; $display("FAIL reset_work_data got %h want 0", work_data); end
        tests_run++;
        if (work_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_work_valid got %b want 0", work_valid); end
        tests_run++;
        if (proto_error !== 1'b0) begin tests_failed++; $display("FAIL reset_proto_error got %b want 0", proto_error); end
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_ping;
        txq.delete();
        send_byte(8'h00);
        tests_run++;
        if (tx_start !== 1'b1 || tx_byte !== 8'h00) begin
            tests_failed++; $display("FAIL ping_latency got start=%b byte=%02h want start=1 byte=00", tx_start, tx_byte);
        end
        wait_tx(1, 100);
        tests_run++;
        if (txq.size() != 1 || txq[0] !== 8'h00) begin
            tests_failed++; $display("FAIL ping_seq got %0d bytes want 1 byte 00", txq.size());
        end
        tests_run++;
        if (wv_cnt != 0) begin tests_failed++; $display("FAIL ping_work_valid got %0d pulses want 0", wv_cnt); end
    endtask

    task automatic test_get_info;
        logic [7:0] exp[$];
        int pe0;
        exp = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0D, 8'h37, 8'h13, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        txq.delete();
        pe0 = pe_cnt;
        pkt = '{8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt(2);
        wait_tx(12, 2000);
        tests_run++;
        if (txq.size() != 12) begin tests_failed++; $display("FAIL info_len got %0d want 12", txq.size()); end
        for (int i = 0; i < 12 && i < txq.size(); i++) begin
            tests_run++;
            if (txq[i] !== exp[i]) begin tests_failed++; $display("FAIL info_byte%0d got %02h want %02h", i, txq[i], exp[i]); end
        end
        tests_run++;
        if (pe_cnt != pe0) begin tests_failed++; $display("FAIL info_proto_error got %0d want 0", pe_cnt - pe0); end
    endtask

    task automatic test_push_job;
        logic [7:0] exp[$];
        int wv0;
        exp = '{8'h04, 8'h00, 8'h00, 8'h03};
        txq.delete();
        wv0 = wv_cnt;
        pkt = '{8'h10, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        send_pkt(2);
        @(negedge sys_clk);
        tests_run++;
        if (work_valid !== 1'b1 || tx_start !== 1'b1) begin
            tests_failed++; $display("FAIL job_latency got wv=%b start=%b want 1 1", work_valid, tx_start);
        end
        wait_tx(4, 1000);
        tests_run++;
        if (work_data !== 96'h0C0B0A090807060504030201) begin
            tests_failed++; $display("FAIL job_work_data got %h want 0c0b0a090807060504030201", work_data);
        end
        tests_run++;
        if (wv_cnt - wv0 != 1) begin tests_failed++; $display("FAIL job_work_valid got %0d pulses want 1", wv_cnt - wv0); end
        tests_run++;
        if (txq.size() != 4) begin tests_failed++; $display("FAIL job_ack_len got %0d want 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            tests_run++;
            if (txq[i] !== exp[i]) begin tests_failed++; $display("FAIL job_ack_byte%0d got %02h want %02h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_short_len;
        logic [7:0] exp[$];
        int pe0;
        exp = '{8'h04, 8'h00, 8'h00, 8'h01};
        txq.delete();
        pe0 = pe_cnt;
        send_byte(8'h02);
        wait_tx(4, 1000);
        tests_run++;
        if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL short_proto_error got %0d want 1", pe_cnt - pe0); end
        tests_run++;
        if (txq.size() != 4) begin tests_failed++; $display("FAIL short_len got %0d want 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            tests_run++;
            if (txq[i] !== exp[i]) begin tests_failed++; $display("FAIL short_byte%0d got %02h want %02h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_bad_type;
        int pe0;
        txq.delete();
        pe0 = pe_cnt;
        pkt = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA};
        send_pkt(1);
        wait_tx(4, 1000);
        tests_run++;
        if (txq.size() != 4 || txq[3] !== 8'h01) begin
            tests_failed++; $display("FAIL badlen_reply got %0d bytes want 4 ending 01", txq.size());
        end
        tests_run++;
        if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL badlen_proto_error got %0d want 1", pe_cnt - pe0); end
    endtask

    task automatic test_oversize;
        logic [7:0] exp[$];
        int pe0;
        exp = '{8'h04, 8'h00, 8'h00, 8'h01};
        txq.delete();
        pe0 = pe_cnt;
        send_byte(8'hFF);
        for (int i = 0; i < 253; i++) send_byte(8'h55);
        repeat (5) @(negedge sys_clk);
        tests_run++;
        if (txq.size() != 0) begin tests_failed++; $display("FAIL oversize_early_tx got %0d bytes want 0", txq.size()); end
        send_byte(8'h55);
        wait_tx(4, 1000);
        tests_run++;
        if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL oversize_proto_error got %0d want 1", pe_cnt - pe0); end
        tests_run++;
        if (txq.size() != 4) begin tests_failed++; $display("FAIL oversize_len got %0d want 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            tests_run++;
            if (txq[i] !== exp[i]) begin tests_failed++; $display("FAIL oversize_byte%0d got %02h want %02h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_timeout;
        int pe0;
        txq.delete();
        pe0 = pe_cnt;
        pkt = '{8'h10, 8'h00, 8'h00};
        send_pkt(2);
        repeat (TIMEOUT + 20) @(negedge sys_clk);
        tests_run++;
        if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL timeout_proto_error got %0d want 1", pe_cnt - pe0); end
        tests_run++;
        if (txq.size() != 0) begin tests_failed++; $display("FAIL timeout_tx got %0d bytes want 0", txq.size()); end
        pkt = '{8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt(2);
        wait_tx(12, 2000);
        tests_run++;
        if (txq.size() != 12 || txq[0] !== 8'h0C || txq[4] !== 8'h13 || txq[11] !== 8'hDE) begin
            tests_failed++; $display("FAIL timeout_recover got %0d bytes want 12 byte INFO", txq.size());
        end
    endtask

    task automatic test_nonce;
        logic [7:0] exp[$];
        exp = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0D, 8'h37, 8'h13, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                8'h08, 8'h00, 8'h00, 8'h04, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        txq.delete();
        send_byte(8'h04);
        send_byte(8'h00);
        pulse_nonce(32'hA1B2C3D4);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_tx(20, 3000);
        tests_run++;
        if (txq.size() != 20) begin tests_failed++; $display("FAIL nonce_len got %0d want 20", txq.size()); end
        for (int i = 0; i < 20 && i < txq.size(); i++) begin
            tests_run++;
            if (txq[i] !== exp[i]) begin tests_failed++; $display("FAIL nonce_byte%0d got %02h want %02h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_two_nonces;
        logic [7:0] exp[$];
        exp = '{8'h08, 8'h00, 8'h00, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11};
        txq.delete();
        send_byte(8'h04);
        pulse_nonce(32'hDEAD0001);
        send_byte(8'h00);
        pulse_nonce(32'h11223344);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_tx(20, 3000);
        repeat (100) @(negedge sys_clk);
        tests_run++;
        if (txq.size() != 20) begin tests_failed++; $display("FAIL two_nonce_len got %0d want 20", txq.size()); end
        for (int i = 0; i < 8 && i + 12 < txq.size(); i++) begin
            tests_run++;
            if (txq[i + 12] !== exp[i]) begin
                tests_failed++; $display("FAIL two_nonce_byte%0d got %02h want %02h", i, txq[i + 12], exp[i]);
            end
        end
    endtask

    task automatic test_mid_send_reset;
        int n0;
        txq.delete();
        pkt = '{8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt(2);
        for (int i = 0; i < 500 && txq.size() < 3; i++) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        tests_run++;
        if (tx_start !== 1'b0 || tx_byte !== 8'h00 || work_data !== 96'h0) begin
            tests_failed++; $display("FAIL midreset_outputs got start=%b byte=%02h work=%h want 0", tx_start, tx_byte, work_data);
        end
        rst = 1'b0;
        n0 = txq.size();
        repeat (150) @(negedge sys_clk);
        tests_run++;
        if (n0 < 3 || txq.size() != n0) begin
            tests_failed++; $display("FAIL midreset_abort got %0d bytes after reset want 0 (had %0d)", txq.size() - n0, n0);
        end
    endtask

    task automatic test_tx_guard;
        tests_run++;
        if (viol != 0) begin tests_failed++; $display("FAIL tx_guard got %0d strobes while busy/back-to-back want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_ping();
        test_get_info();
        test_push_job();
        test_short_len();
        test_bad_type();
        test_oversize();
        test_timeout();
        test_nonce();
        test_two_nonces();
        test_mid_send_reset();
        test_tx_guard();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
